// File: rtl/trace_checker.sv
// Trace checker: compares retired writeback/memory events against a queue
// of expected entries. Define TRACE_CHECKER_LOAD_EN to check loads too.
module trace_checker #(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_tag,
  input  logic [15:0] exp_data,
  input  logic        obs_regwrite,
  input  logic [3:0]  obs_reg,
  input  logic [15:0] obs_wdata,
  input  logic        obs_memwrite,
  input  logic        obs_memread,
  input  logic [15:0] obs_maddr,
  input  logic [15:0] obs_mdata,
  input  logic        obs_halt,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [15:0] fail_idx,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] K_REG   = 2'd0;
  localparam logic [1:0] K_STORE = 2'd1;
  localparam logic [1:0] K_HALT  = 2'd2;
  localparam logic [1:0] K_LOAD  = 2'd3;
  localparam logic [31:0] LAST_CYC = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;

  state_t state;

  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic [15:0]   popCnt;

  logic          memRd;
  logic          full;
  logic          push;
  logic          running;
  logic          aEv;
  logic          bEv;
  logic          multi;
  logic [1:0]    bCnt;
  logic [1:0]    bKind;
  logic [1:0]    nEv;
  logic [AW-1:0] headB;
  logic [33:0]   entA;
  logic [33:0]   entB;
  logic [2:0]    aCode;
  logic [2:0]    bCode;
  logic          evOk;
  logic          haltOk;
  logic [AW:0]   left;
  logic [1:0]    popN;
  logic          instInc;

`ifdef TRACE_CHECKER_LOAD_EN
  assign memRd = obs_memread;
`else
  logic unusedMemRd;
  assign unusedMemRd = obs_memread;
  assign memRd = 1'b0;
`endif

  assign running   = (state == RUN);
  assign full      = (count == (AW+1)'(DEPTH));
  assign exp_ready = rst_n && running && !full;
  assign push      = exp_valid && exp_ready;

  assign aEv   = obs_regwrite;
  assign bCnt  = {1'b0, obs_memwrite} + {1'b0, obs_halt} + {1'b0, memRd};
  assign bEv   = (bCnt != 2'd0);
  assign multi = (bCnt > 2'd1);
  assign nEv   = {1'b0, aEv} + {1'b0, bEv};
  assign headB = rdPtr + AW'(aEv);
  assign entA  = mem[rdPtr];
  assign entB  = mem[headB];
  assign left  = count - (AW+1)'(nEv);

  assign instInc = obs_halt || obs_regwrite || obs_memwrite;

  // Slot B kind, memwrite first, then load, then halt
  always_comb begin
    bKind = K_HALT;
    if (obs_memwrite)
      bKind = K_STORE;
    else if (memRd)
      bKind = K_LOAD;
  end

  // Slot A verdict: writeback event against the head entry
  always_comb begin
    aCode = 3'd0;
    if (aEv) begin
      if (count == '0)
        aCode = 3'd3;
      else if (entA[33:32] != K_REG)
        aCode = 3'd2;
      else if (entA[19:16] != obs_reg ||
               entA[15:0] != obs_wdata)
        aCode = 3'd1;
    end
  end

  // Slot B verdict: memory/halt event against the following entry
  always_comb begin
    bCode = 3'd0;
    if (bEv) begin
      if (multi)
        bCode = 3'd4;
      else if (count < (AW+1)'(nEv))
        bCode = 3'd3;
      else if (entB[33:32] != bKind)
        bCode = 3'd2;
      else if (bKind != K_HALT &&
               (entB[31:16] != obs_maddr ||
                entB[15:0] != obs_mdata))
        bCode = 3'd1;
    end
  end

  assign evOk   = (aCode == 3'd0) && (bCode == 3'd0);
  assign haltOk = evOk && bEv && (bKind == K_HALT);
  assign popN   = (running && evOk) ? nEv : 2'd0;

  // Expected-entry storage, written on accepted offers
  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= {exp_kind, exp_tag, exp_data};
  end

  // Checker FSM, queue pointers, verdict and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      popCnt      <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= 3'd0;
      fail_idx    <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      count <= count + (AW+1)'(push)
                     - (AW+1)'(popN);
      if (running) begin
        cycle_count <= cycle_count + 1;
        if (instInc)
          inst_count <= inst_count + 1;
        rdPtr  <= rdPtr + AW'(popN);
        popCnt <= popCnt + 16'(popN);
        if (aCode != 3'd0) begin
          state     <= FAIL;
          done      <= 1'b1;
          fail_code <= aCode;
          fail_idx  <= popCnt;
        end else if (bCode != 3'd0) begin
          state     <= FAIL;
          done      <= 1'b1;
          fail_code <= bCode;
          fail_idx  <= popCnt + 16'(aEv);
        end else if (haltOk) begin
          done <= 1'b1;
          if (left == '0) begin
            state <= PASS;
            pass  <= 1'b1;
          end else begin
            state     <= FAIL;
            fail_code <= 3'd5;
            fail_idx  <= popCnt + 16'(nEv);
          end
        end else if (cycle_count == LAST_CYC) begin
          state     <= FAIL;
          done      <= 1'b1;
          fail_code <= 3'd6;
          fail_idx  <= popCnt + 16'(nEv);
        end
      end
    end
  end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning expected-entry FIFO depth (power of 2, >=4).
REQ-002 SHALL have parameter MAX_CYCLES, default 100000, meaning timeout limit in clock cycles.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  entry accepted when exp_valid&&exp_ready.
- exp_kind  in  2  0=REG, 1=STORE, 2=HALT, 3=LOAD.
- exp_tag  in  16  REG: register number in [3:0]; STORE/LOAD: address.
- exp_data  in  16  expected value.
- obs_regwrite, obs_reg[3:0], obs_wdata[15:0]  in  writeback event.
- obs_memwrite, obs_memread, obs_maddr[15:0], obs_mdata[15:0]  in  memory-stage event.
- obs_halt  in  1  halt reached memory/writeback.
- done  out  1  checker finished (pass, fail or timeout).
- pass  out  1  run matched trace exactly.
- fail_code  out  3  0 none, 1 data/tag mismatch, 2 kind mismatch, 3 underflow, 4 multi-event, 5 leftover entries, 6 timeout.
- fail_idx  out  16  index of first failing expected entry.
- inst_count, cycle_count  out  32 each  statistics.

Function
REQ-004 SHALL implement FSM RUN -> PASS | FAIL; PASS and FAIL are absorbing until reset.
REQ-005 SHALL assert exp_ready = (state==RUN) && FIFO not full, with no same-cycle bypass: a push in cycle N is poppable from N+1.
REQ-006 SHALL, in RUN each cycle, form slot A = REG event (obs_regwrite) and slot B = one of obs_memwrite (STORE), obs_memread (LOAD, macro only) or obs_halt (HALT), checked in that order against the next 1 or 2 FIFO entries.
REQ-007 SHALL pop exactly the number of events present (0, 1 or 2) per matching cycle.
REQ-008 SHALL treat >1 of {obs_memwrite, obs_halt, obs_memread (macro only)} in one cycle as fail_code 4.
REQ-009 SHALL compare:
- REG: tag[3:0]==obs_reg and data==obs_wdata, tag[15:4] ignored.
- STORE/LOAD: tag==obs_maddr and data==obs_mdata.
- HALT: tag and data ignored.
- Kind differs -> code 2; field differs -> code 1.
REQ-010 SHALL raise fail_code 3 when the FIFO holds fewer entries than events in that cycle.
REQ-011 SHALL, on a matched HALT, go to PASS if the FIFO is then empty, else FAIL with code 5.
REQ-012 SHALL register the FAIL transition one cycle after the offending event; done, pass and fail_code update together and then hold.
REQ-013 SHALL, when both slots fail, report the slot A error and its index.
REQ-014 SHALL set fail_idx to the running count of popped entries at the failing slot, wrapping mod 2^16.
REQ-015 SHALL, in RUN, increment cycle_count every cycle.
REQ-016 SHALL, in RUN, increment inst_count by 1 in any cycle with obs_halt||obs_regwrite||obs_memwrite (once per cycle, loads not counted); the cycle that leaves RUN is counted.
REQ-017 SHALL enter FAIL with code 6 when cycle_count reaches MAX_CYCLES without HALT.
REQ-018 SHALL freeze counters and ignore obs_* and exp_* once done=1.
REQ-019 SHALL wrap FIFO pointers mod DEPTH, and a full FIFO SHALL accept a push in the cycle after a pop frees space.

Reset
REQ-020 SHALL, while rst_n=0 at a clk edge:
- state=RUN, FIFO empty.
- exp_ready=0 during reset, 1 the first cycle after.
- done=0, pass=0, fail_code=0, fail_idx=0, inst_count=0, cycle_count=0.
REQ-021 SHALL discard all FIFO contents and verdicts on reset mid-run.

Configuration
REQ-022 SHALL support macro TRACE_CHECKER_LOAD_EN:
- Defined: obs_memread participates as a LOAD event in slot B.
- Undefined: obs_memread ignored; any kind-3 entry compared in any slot yields code 2.

Verification
REQ-023 Push REG(r1,0x0005), STORE(0x0010,0x0005), HALT; drive regwrite r1=0x0005, then memwrite 0x0010/0x0005, then halt -> pass=1, fail_code=0, inst_count=3.
REQ-024 Same cycle regwrite r2=0x00AA plus memwrite 0x0020=0x1234 against matching two entries -> both popped in one cycle, no fail, inst_count +1.
REQ-025 Expect REG(r3,0x0001), observe r3=0x0002 -> next cycle done=1, pass=0, fail_code=1, fail_idx=0.
REQ-026 regwrite with FIFO empty, including a push in the same cycle -> fail_code=3.
REQ-027 Push 17 entries with DEPTH=16 and no events -> exp_ready=0 after 16 pushes; HALT matched with 15 left -> fail_code=5.
REQ-028 No halt for MAX_CYCLES=50 -> done at cycle_count=50, fail_code=6; reset mid-run -> all outputs 0, exp_ready=1 next cycle.
